ram8x8_fifo_ctrl: RTL and testbench

//  Upstream controller that turns the 8-entry x 8-bit single-port RAM into a 9-deep byte FIFO.

---
 rtl/ram8x8_fifo_ctrl.sv | 99 +++++++++
 tb/tb_ram8x8_fifo_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram8x8_fifo_ctrl.sv
// Turns an external 8x8 single-port RAM into a 9-deep byte FIFO: the RAM holds
// up to 8 bytes and a registered output slot holds the head of the queue.
module ram8x8_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic                 ram_rw,
  output logic [WIDTH-1:0]     ram_wdata,
  input  logic [WIDTH-1:0]     ram_rdata,
  output logic [3:0]           count
);

  localparam int CNT_W = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_BITS);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     ram_cnt_q, ram_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;

  logic slot_free, ram_empty, ram_full, pop;
  logic do_read, do_bypass, do_write;

  assign slot_free = ~out_valid_q | out_ready;
  assign ram_empty = (ram_cnt_q == '0);
  assign ram_full  = (ram_cnt_q == DEPTH);
  assign pop       = out_valid_q & out_ready;

  // One RAM access per cycle: draining into the output slot beats accepting a push.
  assign do_read   = ~clear & slot_free & ~ram_empty;
  assign do_bypass = ~clear & slot_free & ram_empty & in_valid;
  assign do_write  = ~clear & ~slot_free & ~ram_full & in_valid;

  always_comb begin
    in_ready = 1'b0;
    if (!clear) begin
      // Independent of in_valid: a free slot with an empty RAM always takes a bypass.
      if (slot_free) in_ready = ram_empty;
      else           in_ready = ~ram_full;
    end
  end

  assign ram_rw      = do_write;
  assign ram_address = do_write ? wr_ptr_q : rd_ptr_q;
  assign ram_wdata   = in_data;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (do_read) begin
      out_data_d  = ram_rdata;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
      ram_cnt_d   = ram_cnt_q - 1'b1;
    end else if (do_bypass) begin
      out_data_d  = in_data;
      out_valid_d = 1'b1;
    end else if (do_write) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      ram_cnt_d   = ram_cnt_q + 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = 4'(ram_cnt_q) + {3'b000, out_valid_q};

endmodule

// File: tb/tb_ram8x8_fifo_ctrl.sv
// Directed bench for ram8x8_fifo_ctrl with a behavioural 8x8 RAM attached.
module tb_ram8x8_fifo_ctrl;

  logic       clock = 1'b0;
  logic       clear, in_valid, in_ready, out_valid, out_ready, ram_rw;
  logic [7:0] in_data, out_data, ram_wdata, ram_rdata;
  logic [2:0] ram_address;
  logic [3:0] count;
  logic [7:0] mem [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ram8x8_fifo_ctrl dut (
    .clock(clock), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_address(ram_address), .ram_rw(ram_rw), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .count(count)
  );

  always @(posedge clock) if (ram_rw) mem[ram_address] <= ram_wdata;
  assign ram_rdata = mem[ram_address];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       chk_ir;
    logic       ir;
    logic       rw;
    logic [2:0] addr;
    logic       ov;
    logic [7:0] od;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; combinational outputs are sampled at +4.
  task automatic drive(input logic cl, input logic iv, input logic [7:0] d, input logic ordy);
    clear = cl; in_valid = iv; in_data = d; out_ready = ordy;
    #3;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy, input logic chk_ir,
                     input logic ir, input logic rw, input logic [2:0] addr,
                     input logic ov, input logic [7:0] od, input logic [3:0] cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.chk_ir = chk_ir; v.ir = ir; v.rw = rw;
    v.addr = addr; v.ov = ov; v.od = od; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] exp_b;
    int pushed, popped, cyc;
    logic psh, pp;

    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    clear = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    $display("reset: count=%0d out_valid=%0b out_data=%02h", count, out_valid, out_data);
    chk("reset_count", count, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_ram_rw", ram_rw, 0);

    // T1: reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin drive(0, 1, 8'hE0 + 8'(i), 0); tick(); end
    chk("t1_pre_count", count, 3);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 8'hEE, 1);
      $display("t1 clear cycle %0d: in_ready=%0b ram_rw=%0b", i, in_ready, ram_rw);
      chk("t1_clear_in_ready", in_ready, 0);
      chk("t1_clear_ram_rw", ram_rw, 0);
      tick();
      chk("t1_clear_count", count, 0);
      chk("t1_clear_out_valid", out_valid, 0);
      chk("t1_clear_out_data", out_data, 8'h00);
    end
    drive(0, 1, 8'h5A, 0);
    chk("t1_push_in_ready", in_ready, 1);
    tick();
    $display("t1 push 5a: out_valid=%0b out_data=%02h", out_valid, out_data);
    chk("t1_5a_out_valid", out_valid, 1);
    chk("t1_5a_out_data", out_data, 8'h5A);
    drive(0, 0, 8'h00, 1); tick();
    chk("t1_empty_count", count, 0);

    // T2 fill, T3 drain, T4 contention; pointers start at 0
    add(1, 8'h10, 0, 1, 1, 0, 3'd0, 1, 8'h10, 4'd1);
    for (int i = 1; i <= 8; i++)
      add(1, 8'h10 + 8'(i), 0, 1, 1, 1, 3'(i - 1), 1, 8'h10, 4'(1 + i));
    add(1, 8'h99, 0, 1, 0, 0, 3'd0, 1, 8'h10, 4'd9);
    for (int k = 0; k < 8; k++)
      add(0, 8'h00, 1, 1, 0, 0, 3'(k), 1, 8'h11 + 8'(k), 4'(8 - k));
    add(0, 8'h00, 1, 0, 0, 0, 3'd0, 0, 8'h18, 4'd0);
    add(1, 8'h20, 0, 1, 1, 0, 3'd0, 1, 8'h20, 4'd1);
    for (int i = 1; i <= 3; i++)
      add(1, 8'h20 + 8'(i), 0, 1, 1, 1, 3'(i - 1), 1, 8'h20, 4'(1 + i));
    for (int k = 0; k < 3; k++)
      add(1, 8'h30, 1, 1, 0, 0, 3'(k), 1, 8'h21 + 8'(k), 4'(3 - k));
    add(1, 8'h30, 1, 1, 1, 0, 3'd3, 1, 8'h30, 4'd1);
    add(1, 8'h31, 1, 1, 1, 0, 3'd3, 1, 8'h31, 4'd1);
    add(0, 8'h00, 1, 0, 0, 0, 3'd3, 0, 8'h31, 4'd0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      if (vecs[i].chk_ir) chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ir);
      chk($sformatf("v%0d_ram_rw", i), ram_rw, vecs[i].rw);
      chk($sformatf("v%0d_ram_address", i), ram_address, vecs[i].addr);
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ov);
      if (vecs[i].ov) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      $display("vec %0d: iv=%0b d=%02h ordy=%0b -> ov=%0b od=%02h count=%0d",
               i, vecs[i].iv, vecs[i].d, vecs[i].ordy, out_valid, out_data, count);
    end

    // T6: full FIFO, single out_ready pulse; pointers are at 3
    for (int i = 0; i < 9; i++) begin drive(0, 1, 8'h40 + 8'(i), 0); tick(); end
    chk("t6_full_count", count, 9);
    drive(0, 1, 8'h49, 1);
    chk("t6_pulse_in_ready", in_ready, 0);
    chk("t6_pulse_ram_rw", ram_rw, 0);
    chk("t6_pulse_ram_address", ram_address, 3);
    tick();
    $display("t6 pulse: out_data=%02h count=%0d", out_data, count);
    chk("t6_pulse_out_data", out_data, 8'h41);
    chk("t6_pulse_count", count, 8);
    drive(0, 1, 8'h49, 0);
    chk("t6_refill_in_ready", in_ready, 1);
    chk("t6_refill_ram_rw", ram_rw, 1);
    chk("t6_refill_ram_address", ram_address, 3);
    tick();
    $display("t6 refill: count=%0d", count);
    chk("t6_refill_count", count, 9);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 8'h00, 1);
      chk($sformatf("t6_drain%0d_head", i), out_data, 8'h41 + 8'(i));
      tick();
    end
    chk("t6_drained_count", count, 0);

    // T5: 12 pushes and 12 pops interleaved, scoreboard-checked
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 12 || popped < 12) && cyc < 200) begin
      drive(0, pushed < 12, 8'h60 + 8'(pushed), cyc[2]);
      psh = in_valid & in_ready;
      pp  = out_valid & out_ready;
      if (pp) begin
        exp_b = (q.size() > 0) ? q.pop_front() : 8'hXX;
        $display("t5 pop %0d: out_data=%02h expected=%02h", popped, out_data, exp_b);
        chk($sformatf("t5_pop%0d", popped), out_data, exp_b);
        popped++;
      end
      if (psh) begin q.push_back(in_data); pushed++; end
      tick();
      chk($sformatf("t5_cyc%0d_count", cyc), count, q.size());
      cyc++;
    end
    chk("t5_done_in_budget", (cyc < 200) ? 1 : 0, 1);
    chk("t5_final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
